lsu_handshake: RTL

- Parametrised load/store unit that replaces the combinational single-cycle dmem port with a request/response handshake memory interface.
- Sits between the hart's execute stage and data memory, and stalls the core until the access completes.
- Supports XLEN 32 or 64, byte/half/word/(double) accesses with byte-lane masking, and sign/zero extension.
- Traps misaligned or illegal accesses without touching memory.

---
 rtl/lsu_handshake_if.sv | 39 +++
 rtl/lsu_handshake.sv | 138 +++++++++++++
 2 files changed

// File: rtl/lsu_handshake_if.sv
// Bundle of the LSU signals: the core-side request/response and the memory-side request/ack.
// The lsu modport is the unit's view; env is the view of the core plus the memory around it.
interface lsu_handshake_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic                req_valid;
   logic                req_ready;
   logic                req_wen;
   logic [2:0]          req_funct3;
   logic [ADDR_W-1:0]   req_addr;
   logic [XLEN-1:0]     req_wdata;
   logic                rsp_valid;
   logic [XLEN-1:0]     rsp_rdata;
   logic                rsp_trap;
   logic                mem_req;
   logic                mem_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ren;
   logic                mem_wen;
   logic [XLEN-1:0]     mem_wdata;
   logic [XLEN/8-1:0]   mem_mask;
   logic                mem_valid;
   logic [XLEN-1:0]     mem_rdata;

   modport lsu (
      input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_trap,
      output mem_req, mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
      input  mem_ready, mem_valid, mem_rdata
   );

   modport env (
      output req_valid, req_wen, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_trap,
      input  mem_req, mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
      output mem_ready, mem_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_handshake.sv
// Load/store unit: turns one core access into a request/ack memory transaction, with lane
// masking, load extension and a trap path for misaligned or illegal accesses.
//
// state | meaning
// IDLE  | ready for a new core access
// REQ   | memory request held until the memory accepts it
// WAIT  | waiting for read data / write acknowledge
// RESP  | one-cycle response to the core
module lsu_handshake #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   lsu_handshake_if.lsu bus
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t             state, state_nxt;
   logic               r_wen;
   logic [2:0]         r_funct3;
   logic [ADDR_W-1:0]  r_addr;
   logic [XLEN-1:0]    r_wdata;
   logic [XLEN-1:0]    rdata_q;
   logic               trap_q;

   logic               legal, misaligned, trap_d;
   logic [OFF_W-1:0]   off;
   logic [NB-1:0]      ones;
   logic [XLEN-1:0]    sh, ext;
   logic               sgn;

   // Decode of the incoming access, used only on the accepting cycle.
   always_comb begin
      legal = 1'b0;
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b011:                 legal = (XLEN == 64);
         3'b100, 3'b101:         legal = !bus.req_wen;
         3'b110:                 legal = !bus.req_wen && (XLEN == 64);
         default:                legal = 1'b0;
      endcase
      misaligned = 1'b0;
      case (bus.req_funct3[1:0])
         2'b01:   misaligned = bus.req_addr[0];
         2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
         2'b11:   misaligned = (bus.req_addr[2:0] != 3'b000);
         default: misaligned = 1'b0;
      endcase
      trap_d = !legal || misaligned;
   end

   // Lane math works off the registered access so outputs stay stable while REQ is held.
   always_comb begin
      off = r_addr[OFF_W-1:0];
      sgn = !r_funct3[2];
      case (r_funct3[1:0])
         2'b00:   ones = NB'(1);
         2'b01:   ones = NB'(3);
         2'b10:   ones = NB'(15);
         default: ones = '1;
      endcase
      sh = bus.mem_rdata >> {off, 3'b000};
      case (r_funct3[1:0])
         2'b00:   ext = XLEN'($signed({sgn & sh[7],  sh[7:0]}));
         2'b01:   ext = XLEN'($signed({sgn & sh[15], sh[15:0]}));
         2'b10:   ext = XLEN'($signed({sgn & sh[31], sh[31:0]}));
         default: ext = sh;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_trap  = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 1'b0;
      bus.mem_wdata = '0;
      bus.mem_mask  = '0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nxt = trap_d ? RESP : REQ;
         end
         REQ: begin
            bus.mem_req   = 1'b1;
            bus.mem_addr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus.mem_ren   = !r_wen;
            bus.mem_wen   = r_wen;
            bus.mem_wdata = r_wdata << {off, 3'b000};
            bus.mem_mask  = ones << off;
            if (bus.mem_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.mem_valid) state_nxt = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = rdata_q;
            bus.rsp_trap  = trap_q;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wen    <= 1'b0;
         r_funct3 <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         rdata_q  <= '0;
         trap_q   <= 1'b0;
      end else if (state == IDLE && bus.req_valid) begin
         r_wen    <= bus.req_wen;
         r_funct3 <= bus.req_funct3;
         r_addr   <= bus.req_addr;
         r_wdata  <= bus.req_wdata;
         rdata_q  <= '0;
         trap_q   <= trap_d;
      end else if (state == WAIT && bus.mem_valid && !r_wen) begin
         rdata_q  <= ext;
      end
   end
endmodule
